// File: rtl/hazard_unit.sv
// Hazard detection and forwarding control for the five-stage pipeline.
// Covers operand forwarding, load-use bubbles of configurable depth, branch flushes and perf counters.
module hazard_unit #(
    parameter int REG_ADDR_WIDTH    = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter bit FWD_EN            = 1'b1,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] rs1d,
    input  logic [REG_ADDR_WIDTH-1:0] rs2d,
    input  logic [REG_ADDR_WIDTH-1:0] rs1e,
    input  logic [REG_ADDR_WIDTH-1:0] rs2e,
    input  logic [REG_ADDR_WIDTH-1:0] rde,
    input  logic [REG_ADDR_WIDTH-1:0] rdm,
    input  logic [REG_ADDR_WIDTH-1:0] rdw,
    input  logic                      regwritee,
    input  logic                      regwritem,
    input  logic                      regwritew,
    input  logic [1:0]                resultsrce,
    input  logic                      pcsrce,
    output logic [1:0]                forwardae,
    output logic [1:0]                forwardbe,
    output logic                      stallf,
    output logic                      stalld,
    output logic                      flushd,
    output logic                      flushe,
    output logic [CNT_WIDTH-1:0]      stall_cnt,
    output logic [CNT_WIDTH-1:0]      flush_cnt
);

    localparam int CW = (LOAD_STALL_CYCLES > 1) ? $clog2(LOAD_STALL_CYCLES + 1) : 1;
    localparam logic [CW-1:0]        RELOAD  = CW'(LOAD_STALL_CYCLES - 1);
    localparam logic [CW-1:0]        CNT_ONE = CW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [REG_ADDR_WIDTH-1:0] X0 = {REG_ADDR_WIDTH{1'b0}};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t              state_r;
    logic [CW-1:0]       cnt_r;
    logic                lu_s;
    logic                raw_s;
    logic                stall_s;
    logic [1:0]          fwd_a_s;
    logic [1:0]          fwd_b_s;

    // Memory stage wins over writeback because it holds the younger value.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_WIDTH-1:0] rs,
        input logic [REG_ADDR_WIDTH-1:0] rd_m,
        input logic                      we_m,
        input logic [REG_ADDR_WIDTH-1:0] rd_w,
        input logic                      we_w
    );
        logic [1:0] sel;
        if (we_m && (rd_m != X0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (we_w && (rd_w != X0) && (rd_w == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    function automatic logic raw_hit(
        input logic [REG_ADDR_WIDTH-1:0] rs,
        input logic [REG_ADDR_WIDTH-1:0] rd_e,
        input logic                      we_e,
        input logic [REG_ADDR_WIDTH-1:0] rd_m,
        input logic                      we_m,
        input logic [REG_ADDR_WIDTH-1:0] rd_w,
        input logic                      we_w
    );
        return (rs != X0) &&
               ((we_e && (rd_e == rs)) || (we_m && (rd_m == rs)) || (we_w && (rd_w == rs)));
    endfunction

    // Hazard decode: forwarding selects, stall and flush controls.
    always_comb begin
        lu_s    = (resultsrce == 2'b01) && (rde != X0) && ((rde == rs1d) || (rde == rs2d));
        raw_s   = raw_hit(rs1d, rde, regwritee, rdm, regwritem, rdw, regwritew) ||
                  raw_hit(rs2d, rde, regwritee, rdm, regwritem, rdw, regwritew);
        fwd_a_s = 2'b00;
        fwd_b_s = 2'b00;
        stall_s = 1'b0;

        if (FWD_EN) begin
            fwd_a_s = fwd_sel(rs1e, rdm, regwritem, rdw, regwritew);
            fwd_b_s = fwd_sel(rs2e, rdm, regwritem, rdw, regwritew);
            stall_s = !pcsrce && ((state_r == STALL) || lu_s);
        end else begin
            stall_s = !pcsrce && raw_s;
        end

        if (rst) begin
            forwardae = 2'b00;
            forwardbe = 2'b00;
            stallf    = 1'b0;
            stalld    = 1'b0;
            flushd    = 1'b0;
            flushe    = 1'b0;
        end else begin
            forwardae = fwd_a_s;
            forwardbe = fwd_b_s;
            stallf    = stall_s;
            stalld    = stall_s;
            flushd    = pcsrce;
            flushe    = pcsrce || stall_s;
        end
    end

    // Load-use bubble sequencer; the first bubble is issued from IDLE, the rest from STALL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
        end else if (!FWD_EN || pcsrce) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (lu_s && (LOAD_STALL_CYCLES > 1)) begin
                        state_r <= STALL;
                        cnt_r   <= RELOAD;
                    end else begin
                        state_r <= IDLE;
                        cnt_r   <= {CW{1'b0}};
                    end
                end
                STALL: begin
                    if (cnt_r <= CNT_ONE) begin
                        state_r <= IDLE;
                        cnt_r   <= {CW{1'b0}};
                    end else begin
                        state_r <= STALL;
                        cnt_r   <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= {CW{1'b0}};
                end
            endcase
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= {CNT_WIDTH{1'b0}};
            flush_cnt <= {CNT_WIDTH{1'b0}};
        end else begin
            if (stalld && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt <= stall_cnt;
            end
            if (pcsrce && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                flush_cnt <= flush_cnt;
            end
        end
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Parametrised hazard-detection and forwarding controller for the 5-stage pipelined cpu (fetch/decode/execute/memory/writeback).
- Drives operand-forwarding selects into execute, stall enables on the fetch/decode pipe registers, and flushes on decode/execute.
- Generalises basic hazard handling with configurable load-use bubble depth (multi-cycle data memory), forwarding on/off mode, and saturating stall/flush performance counters.

Parameters:
REG_ADDR_WIDTH, 5, register address width
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (>=1)
FWD_EN, 1, 1 = forwarding enabled; 0 = all RAW hazards resolved by stalling
CNT_WIDTH, 16, width of performance counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
rs1d  in  REG_ADDR_WIDTH  decode source reg 1 (instrd[19:15])
rs2d  in  REG_ADDR_WIDTH  decode source reg 2 (instrd[24:20])
rs1e  in  REG_ADDR_WIDTH  execute source reg 1
rs2e  in  REG_ADDR_WIDTH  execute source reg 2
rde  in  REG_ADDR_WIDTH  execute dest reg
rdm  in  REG_ADDR_WIDTH  memory dest reg
rdw  in  REG_ADDR_WIDTH  writeback dest reg
regwritee  in  1  execute regwrite
regwritem  in  1  memory regwrite
regwritew  in  1  writeback regwrite
resultsrce  in  2  execute resultsrc (2'b01 = load)
pcsrce  in  1  taken branch/jump resolved in execute
forwardae  out  2  ALU srcA select: 00 rd1e, 01 result (W), 10 aluresultm (M)
forwardbe  out  2  ALU srcB select, same encoding
stallf  out  1  hold pc
stalld  out  1  hold fetch->decode register
flushd  out  1  clear fetch->decode register
flushe  out  1  clear decode->execute register (insert bubble)
stall_cnt  out  CNT_WIDTH  cycles with stalld=1, saturating
flush_cnt  out  CNT_WIDTH  cycles with pcsrce=1, saturating

Behaviour:
- Register x0 never causes a hazard or forward; any match against address 0 is ignored.
- Forwarding (FWD_EN=1), combinational, per operand:
  - 10 if regwritem && rdm!=0 && rdm==rsXe;
  - else 01 if regwritew && rdw!=0 && rdw==rsXe;
  - else 00.
  - M has priority over W.
- FWD_EN=0: forwardae=forwardbe=00 always.
- Load-use detect (FWD_EN=1): lu = (resultsrce==01) && rde!=0 && (rde==rs1d || rde==rs2d).
- RAW detect (FWD_EN=0): raw = rsXd!=0 matching rde&&regwritee, rdm&&regwritem, or rdw&&regwritew.
  - Stall asserted combinationally while raw holds; stall counter FSM unused.
- Stall FSM (FWD_EN=1), states IDLE, STALL; down-counter cnt, width clog2(LOAD_STALL_CYCLES+1).
  - IDLE && lu && !pcsrce: stallf=stalld=flushe=1 this cycle. If LOAD_STALL_CYCLES>1, go to STALL at the next edge with cnt=LOAD_STALL_CYCLES-1; else stay IDLE.
  - STALL: stallf=stalld=flushe=1; cnt decrements each edge; cnt==1 -> IDLE at that edge. Total bubbles = LOAD_STALL_CYCLES exactly.
  - lu is not re-evaluated while in STALL.
- Branch flush: pcsrce=1 -> flushd=flushe=1 and stallf=stalld=0 that cycle.
  - pcsrce overrides any stall (wrong-path instruction in decode).
  - FSM returns to IDLE and cnt clears at the next edge.
- Simultaneous lu and pcsrce: flush only, no stall, FSM stays IDLE.
- Performance counters:
  - stall_cnt increments on each edge where stalld=1; flush_cnt increments on each edge where pcsrce=1.
  - Both saturate at all-ones (no wrap).
- Reset (asynchronous, any cycle including mid-stall):
  - FSM=IDLE, cnt=0, stall_cnt=flush_cnt=0.
  - While rst=1, all of stallf/stalld/flushd/flushe=0 and forwardae/forwardbe=00 regardless of inputs.
- Latency: all hazard outputs are combinational from inputs plus FSM state; no output register.

Test Plan:
- Forwarding: FWD_EN=1, rs1e=5, rdm=5, regwritem=1, rdw=5, regwritew=1 -> forwardae=10; drop regwritem -> forwardae=01; rs1e=0 with rdm=0 -> 00.
- Load-use, LOAD_STALL_CYCLES=1: resultsrce=01, rde=7, rs2d=7 -> stallf=stalld=flushe=1 for exactly 1 cycle; stall_cnt=1 afterward.
- Load-use, LOAD_STALL_CYCLES=3: same stimulus -> 3 consecutive stall+bubble cycles, then outputs 0; stall_cnt=3.
- Branch vs stall: lu and pcsrce=1 same cycle -> flushd=flushe=1, stallf=stalld=0; flush_cnt=1. pcsrce=1 during STALL cycle 2 of 3 -> flush, FSM IDLE next cycle.
- FWD_EN=0: rs1d=3 matches rdm=3, regwritem=1 -> stall asserted while match holds, forwardae=00 throughout.
- Reset mid-stall (cycle 2 of 3) -> outputs 0 immediately, counters 0, FSM IDLE after release; saturation check with CNT_WIDTH=2 -> stall_cnt holds at 3.
